i2c_slave: RTL and testbench

- I2C target (responder) for the bus side opposite our I2C master; it answers 7-bit-addressed transactions on SCL/SDA.
- Bridges those transactions to a simple byte-wide register-access port: register-pointer write, data writes, data reads, auto-incrementing pointer.
- Pure target: never drives SCL (no clock stretching). Drives SDA open-drain through sda_oe.
- Sits in the same I2C subsystem; the bench pairs it with our master or a behavioural master.

---
 rtl/i2c_slave_if.sv | 17 +
 rtl/i2c_slave.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_slave.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// Bus pins and byte-wide register-access port of the I2C target.
interface i2c_slave_if #(parameter int PTR_W = 8);
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_wr;
  logic             reg_rd;
  logic [7:0]       reg_rdata;
  logic             busy;

  modport slave  (input  scl_i, sda_i, reg_rdata,
                  output sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy);
  modport master (output scl_i, sda_i, reg_rdata,
                  input  sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy);
endinterface

// File: rtl/i2c_slave.sv
// 7-bit I2C target bridging pointer/write/read transactions to a byte register port.
// No clock stretching; SDA is driven open-drain through sda_oe.
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         PTR_W    = 8
) (
  input  logic       clk,
  input  logic       nrst,
  i2c_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       scl_q, sda_q;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rw_q, rw_d;
  logic             ptr_done_q, ptr_done_d;
  logic             ack_q, ack_d;
  logic             sda_oe_q, sda_oe_d;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;

  // [1] is the synchronised level, [2] its one-clk delay for edge detection
  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_s    = scl_q[1];
  assign scl_p    = scl_q[2];
  assign sda_s    = sda_q[1];
  assign sda_p    = sda_q[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      rw_q       <= 1'b0;
      ptr_done_q <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= {scl_q[1:0], bus.scl_i};
      sda_q      <= {sda_q[1:0], bus.sda_i};
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      ptr_done_q <= ptr_done_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    ptr_done_d = ptr_done_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    load_d     = rd_q;
    busy_d     = busy_q;

    // Read data arrives the clk after the reg_rd strobe; present its MSB at once
    if (load_q && state_q == RDATA) begin
      shreg_d  = bus.reg_rdata;
      sda_oe_d = ~bus.reg_rdata[7];
    end

    if (scl_rise && bitcnt_q != 4'd8 &&
        (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
      shreg_d  = {shreg_q[6:0], sda_s};
      bitcnt_d = bitcnt_q + 4'd1;
    end

    case (state_q)
      ADDR: if (scl_fall && bitcnt_q == 4'd8) begin
        bitcnt_d = '0;
        if (shreg_q[7:1] == SLV_ADDR) begin
          sda_oe_d = 1'b1;
          busy_d   = 1'b1;
          rw_d     = shreg_q[0];
          state_d  = ADDR_ACK;
        end else begin
          state_d  = WAIT_STOP;
        end
      end
      ADDR_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        bitcnt_d = '0;
        if (rw_q) begin
          rd_d    = 1'b1;
          state_d = RDATA;
        end else if (!ptr_done_q) begin
          state_d = PTR;
        end else begin
          state_d = WDATA;
        end
      end
      PTR: if (scl_fall && bitcnt_q == 4'd8) begin
        sda_oe_d   = 1'b1;
        addr_d     = PTR_W'(shreg_q);
        ptr_done_d = 1'b1;
        bitcnt_d   = '0;
        state_d    = PTR_ACK;
      end
      PTR_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        state_d  = WDATA;
      end
      WDATA: if (scl_fall && bitcnt_q == 4'd8) begin
        sda_oe_d = 1'b1;
        wdata_d  = shreg_q;
        wr_d     = 1'b1;
        bitcnt_d = '0;
        state_d  = WDATA_ACK;
      end
      WDATA_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        addr_d   = addr_q + PTR_W'(1);
        state_d  = WDATA;
      end
      RDATA: begin
        if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
        else if (scl_fall && bitcnt_q == 4'd8) begin
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
          state_d  = RDATA_ACK;
        end else if (scl_fall && bitcnt_q != 4'd0) begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          sda_oe_d = ~shreg_q[6];
        end
      end
      RDATA_ACK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            ack_d  = 1'b1;
            addr_d = addr_q + PTR_W'(1);
          end else begin
            state_d = WAIT_STOP;
          end
        end else if (scl_fall && ack_q) begin
          ack_d    = 1'b0;
          rd_d     = 1'b1;
          bitcnt_d = '0;
          state_d  = RDATA;
        end
      end
      default: ;
    endcase

    // Bus conditions override any bit-level activity in the same cycle
    if (stop_ev) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ptr_done_d = 1'b0;
      ack_d      = 1'b0;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      load_d     = 1'b0;
    end else if (start_ev) begin
      if (state_q == IDLE) ptr_done_d = 1'b0;
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      ack_d    = 1'b0;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      load_d   = 1'b0;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_rd    = rd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Behavioural I2C master plus register-bank model around i2c_slave; scoreboards register strobes.
module tb_i2c_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic [7:0] rdata_q;
  logic [7:0] mem [256];
  int errors = 0, checks = 0;
  int wr_cnt = 0, rd_cnt = 0;
  bit oe_seen = 0, busy_seen = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_t        w_mon;
  logic [7:0] a_mon;

  i2c_slave_if #(.PTR_W(8)) bus();
  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & ~bus.sda_oe;
  assign bus.reg_rdata = rdata_q;

  i2c_slave #(.SLV_ADDR(7'h50), .PTR_W(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  // Register bank: registered read data, valid the clk after reg_rd
  always @(posedge clk) begin
    if (!nrst) begin
      mem[8'h20] <= 8'h96;
      mem[8'h21] <= 8'h3C;
    end
    if (bus.reg_rd) rdata_q <= mem[bus.reg_addr];
    if (bus.reg_wr) mem[bus.reg_addr] <= bus.reg_wdata;
  end

  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1;
    if (bus.busy) busy_seen = 1;
    if (bus.reg_wr) begin
      wr_cnt++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%h data=%h with nothing expected", bus.reg_addr, bus.reg_wdata);
      end else begin
        w_mon = exp_wr.pop_front();
        if (w_mon.a !== bus.reg_addr || w_mon.d !== bus.reg_wdata) begin
          errors++;
          $display("FAIL wr_scoreboard: got addr=%h data=%h expected addr=%h data=%h",
                   bus.reg_addr, bus.reg_wdata, w_mon.a, w_mon.d);
        end
      end
    end
    if (bus.reg_rd) begin
      rd_cnt++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: addr=%h with nothing expected", bus.reg_addr);
      end else begin
        a_mon = exp_rd.pop_front();
        if (a_mon !== bus.reg_addr) begin
          errors++;
          $display("FAIL rd_scoreboard: got addr=%h expected %h", bus.reg_addr, a_mon);
        end
      end
    end
    if (bus.reg_wr && bus.reg_rd) begin
      checks++; errors++;
      $display("FAIL wr_rd_overlap: both strobes high, got 1 expected 0");
    end
    if ((bus.reg_wr && prev_wr) || (bus.reg_rd && prev_rd)) begin
      checks++; errors++;
      $display("FAIL strobe_width: strobe high 2 clks, expected 1");
    end
    prev_wr = bus.reg_wr;
    prev_rd = bus.reg_rd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(2);
  endtask

  // Ends with SDA just risen; busy must still be high 2 clks later and low at 3
  task automatic i2c_stop(input logic was_busy);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2);
    chk("busy_hold", 32'(bus.busy), 32'(was_busy));
    tick(1);
    chk("busy_fall", 32'(bus.busy), 0);
    tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q/2);
    b = bus.sda_i; tick(Q - Q/2);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic nack;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(nack);
    ack = ~nack;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic do_write(input logic [6:0] a7, input logic [7:0] ptr, input logic [7:0] d0,
                          input logic [7:0] d1, input int nd, input logic exp_ack);
    logic ack;
    logic [7:0] dd[2];
    wr_t w;
    int wc0;
    dd[0] = d0; dd[1] = d1;
    wc0 = wr_cnt;
    if (exp_ack) for (int i = 0; i < nd; i++) begin
      w.a = ptr + 8'(i);
      w.d = dd[i];
      exp_wr.push_back(w);
    end
    oe_seen = 0; busy_seen = 0;
    i2c_start;
    send_byte({a7, 1'b0}, ack); chk("addr_ack", 32'(ack), 32'(exp_ack));
    send_byte(ptr, ack);        chk("ptr_ack", 32'(ack), 32'(exp_ack));
    for (int i = 0; i < nd; i++) begin
      send_byte(dd[i], ack);    chk("data_ack", 32'(ack), 32'(exp_ack));
    end
    i2c_stop(exp_ack);
    if (!exp_ack) begin
      chk("no_sda_oe", 32'(oe_seen), 0);
      chk("no_busy", 32'(busy_seen), 0);
    end
    chk("wr_count", 32'(wr_cnt - wc0), exp_ack ? 32'(nd) : 0);
    chk("wr_drain", 32'(exp_wr.size()), 0);
  endtask

  task automatic do_read(input logic [7:0] ptr, input logic [7:0] e0, input logic [7:0] e1);
    logic ack;
    logic [7:0] v;
    int rc0;
    rc0 = rd_cnt;
    exp_rd.push_back(ptr);
    exp_rd.push_back(ptr + 8'd1);
    i2c_start;
    send_byte(8'hA0, ack); chk("rd_addr_ack", 32'(ack), 1);
    send_byte(ptr, ack);   chk("rd_ptr_ack", 32'(ack), 1);
    i2c_start;
    send_byte(8'hA1, ack); chk("rd_addr_r_ack", 32'(ack), 1);
    recv_byte(1'b1, v);    chk("rd_byte0", 32'(v), 32'(e0));
    recv_byte(1'b0, v);    chk("rd_byte1", 32'(v), 32'(e1));
    tick(4);
    chk("rd_release", 32'(bus.sda_oe), 0);
    i2c_stop(1'b1);
    chk("rd_count", 32'(rd_cnt - rc0), 2);
    chk("rd_drain", 32'(exp_rd.size()), 0);
  endtask

  typedef struct {
    logic [6:0] a7;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    logic       ack;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic ack;
    int wc0;
    vecs[0] = '{7'h50, 8'h10, 8'h5A, 8'hC3, 2, 1'b1};  // basic two-byte write
    vecs[1] = '{7'h51, 8'h33, 8'h77, 8'h00, 1, 1'b0};  // 0xA2: not our address
    vecs[2] = '{7'h50, 8'hFF, 8'h11, 8'h22, 2, 1'b1};  // pointer wraps FF -> 00
    vecs[3] = '{7'h50, 8'h80, 8'h01, 8'h00, 1, 1'b1};
    vecs[4] = '{7'h50, 8'h40, 8'h00, 8'h00, 0, 1'b1};  // pointer only, no write

    tick(3);
    chk("rst_sda_oe", 32'(bus.sda_oe), 0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 0);
    chk("rst_reg_wdata", 32'(bus.reg_wdata), 0);
    chk("rst_reg_wr", 32'(bus.reg_wr), 0);
    chk("rst_reg_rd", 32'(bus.reg_rd), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    nrst = 1'b1;
    tick(Q);

    for (int i = 0; i < 5; i++)
      do_write(vecs[i].a7, vecs[i].ptr, vecs[i].d0, vecs[i].d1, vecs[i].nd, vecs[i].ack);

    do_read(8'h20, 8'h96, 8'h3C);
    do_read(8'hFF, 8'h11, 8'h22);

    // STOP in the middle of a data byte
    wc0 = wr_cnt;
    i2c_start;
    send_byte(8'hA0, ack); chk("abort_addr_ack", 32'(ack), 1);
    send_byte(8'h50, ack); chk("abort_ptr_ack", 32'(ack), 1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop(1'b1);
    chk("abort_no_wr", 32'(wr_cnt - wc0), 0);
    do_write(7'h50, 8'h60, 8'hA5, 8'h00, 1, 1'b1);

    // Reset while the target is pulling SDA for the address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) put_bit(1'(8'hA0 >> i));
    tick(4);
    chk("ack_driven", 32'(bus.sda_oe), 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_sda_oe", 32'(bus.sda_oe), 0);
    chk("mid_rst_reg_addr", 32'(bus.reg_addr), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_wdata", 32'(bus.reg_wdata), 0);
    tick(3);
    nrst = 1'b1;
    tick(2);
    scl_m = 1'b1; tick(Q);
    scl_m = 1'b0; tick(2);
    chk("post_rst_sda_oe", 32'(bus.sda_oe), 0);
    i2c_stop(1'b0);
    do_write(7'h50, 8'h05, 8'hEE, 8'h00, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
